// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the glitch-free programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam int DEFAULT_HALF = 1;

endpackage

// File: rtl/clk_div_if.sv
// Half-period change request channel from config logic (valid/ready plus error pulse).
interface clk_div_if #(
  parameter int DIV_W = 8
);

  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_half,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_half,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clk_div_core.sv
// Counter/toggle datapath: clk_out flips every `half` edges while run=1; load forces a clean low restart.
// Registered outputs (1 cycle); no backpressure.
module clk_div_core #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] half,
  input  logic             load,
  output logic             clk_out,
  output logic             boundary,
  output logic             rise
);

  logic [DIV_W-1:0] cnt;
  logic             toggle;

  assign toggle   = run && (cnt == half - DIV_W'(1));
  // Period boundary: the falling toggle of clk_out.
  assign boundary = toggle && clk_out;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      rise    <= 1'b0;
    end else if (load) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      rise    <= 1'b0;
    end else if (toggle) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
      rise    <= ~clk_out;
    end else begin
      cnt     <= run ? cnt + DIV_W'(1) : cnt;
      rise    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for a glitch-free divide-by-2H clock; ratio changes land only on period boundaries.
// Outputs registered (1 cycle); cfg_ready is low in STOP or while a change is pending.
module clk_div_ctrl #(
  parameter int DIV_W        = 8,
  parameter int DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  clk_div_if.slave         cfg,
  output logic             clk_out,
  output logic             rise_en,
  output logic             running,
  output logic [DIV_W-1:0] cur_half
);

  import clk_div_pkg::*;

  state_t           state, state_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic [DIV_W-1:0] pend_half, pend_half_nxt;
  logic [DIV_W-1:0] cur_half_nxt;
  logic             cfg_err_nxt;
  logic             load, boundary, apply_pend, accept;

  assign cfg.cfg_ready = (state != ST_STOP) && !pend_valid;
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign running       = (state != ST_OFF);

  clk_div_core #(.DIV_W(DIV_W)) u_core (
    .clk_in   (clk_in),
    .rst      (rst),
    .run      (running),
    .half     (cur_half),
    .load     (load),
    .clk_out  (clk_out),
    .boundary (boundary),
    .rise     (rise_en)
  );

  always_comb begin
    state_nxt      = state;
    cur_half_nxt   = cur_half;
    pend_valid_nxt = pend_valid;
    pend_half_nxt  = pend_half;
    cfg_err_nxt    = 1'b0;
    load           = 1'b0;
    apply_pend     = 1'b0;

    case (state)
      ST_OFF: begin
        load = 1'b1;
        if (enable) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!enable && !clk_out) begin
          // Low level already held: stop right here, nothing to finish.
          state_nxt  = ST_OFF;
          load       = 1'b1;
          apply_pend = pend_valid;
        end else if (!enable && boundary) begin
          state_nxt  = ST_OFF;
          apply_pend = pend_valid;
        end else if (!enable) begin
          state_nxt  = ST_STOP;
        end else begin
          apply_pend = boundary && pend_valid;
        end
      end
      ST_STOP: begin
        if (enable)        state_nxt = ST_RUN;
        else if (boundary) state_nxt = ST_OFF;
        apply_pend = boundary && pend_valid;
      end
      default: state_nxt = ST_OFF;
    endcase

    if (apply_pend) begin
      cur_half_nxt   = pend_half;
      pend_valid_nxt = 1'b0;
    end

    if (accept && cfg.cfg_half == '0) begin
      cfg_err_nxt = 1'b1;
    end else if (accept) begin
      // Divider idle now or after this edge: no period to protect, apply at once.
      if (state == ST_OFF || state_nxt == ST_OFF) begin
        cur_half_nxt = cfg.cfg_half;
      end else begin
        pend_valid_nxt = 1'b1;
        pend_half_nxt  = cfg.cfg_half;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= ST_OFF;
      cur_half    <= DIV_W'(DEFAULT_HALF);
      pend_valid  <= 1'b0;
      pend_half   <= '0;
      cfg.cfg_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur_half    <= cur_half_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_half   <= pend_half_nxt;
      cfg.cfg_err <= cfg_err_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: start/stop, ratio changes, error pulse and async reset.
module tb_clk_div_ctrl;

  localparam int DIV_W = 8;

  logic             clk_in;
  logic             rst;
  logic             enable;
  logic             clk_out;
  logic             rise_en;
  logic             running;
  logic [DIV_W-1:0] cur_half;

  int total = 0;
  int bad   = 0;

  clk_div_if #(.DIV_W(DIV_W)) cfg_if ();

  clk_div_ctrl #(.DIV_W(DIV_W), .DEFAULT_HALF(1)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .enable   (enable),
    .cfg      (cfg_if.slave),
    .clk_out  (clk_out),
    .rise_en  (rise_en),
    .running  (running),
    .cur_half (cur_half)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  initial begin
    rst              = 1'b1;
    enable           = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_half  = '0;
    step();
    step();
    chk("rst_clk_out",  32'(clk_out), 32'd0);
    chk("rst_rise",     32'(rise_en), 32'd0);
    chk("rst_running",  32'(running), 32'd0);
    chk("rst_cur_half", 32'(cur_half), 32'd1);
    chk("rst_ready",    32'(cfg_if.cfg_ready), 32'd1);
    chk("rst_err",      32'(cfg_if.cfg_err), 32'd0);
    rst = 1'b0;

    // H=1: plain divide-by-2
    enable = 1'b1;
    step();
    chk("h1_entry_run", 32'(running), 32'd1);
    chk("h1_entry_clk", 32'(clk_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("h1_clk",  32'(clk_out), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("h1_rise", 32'(rise_en), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    enable = 1'b0;
    step();
    chk("h1_stop_run", 32'(running), 32'd0);
    chk("h1_stop_clk", 32'(clk_out), 32'd0);

    // H=3 programmed while OFF: 3 low, 3 high
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 8'd3;
    chk("h3_ready_off", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("h3_cur_half", 32'(cur_half), 32'd3);
    chk("h3_off_run",  32'(running), 32'd0);
    enable = 1'b1;
    step();
    chk("h3_entry_clk", 32'(clk_out), 32'd0);
    for (int k = 1; k < 12; k++) begin
      step();
      chk("h3_clk",  32'(clk_out), ((k / 3) % 2 == 1) ? 32'd1 : 32'd0);
      chk("h3_rise", 32'(rise_en), (k % 6 == 3) ? 32'd1 : 32'd0);
    end
    // disable exactly on the falling boundary: straight to OFF
    enable = 1'b0;
    step();
    chk("h3_bnd_off_run", 32'(running), 32'd0);
    chk("h3_bnd_off_clk", 32'(clk_out), 32'd0);

    // H=4 running, change to 2 mid-high
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 8'd4;
    step();
    cfg_if.cfg_valid = 1'b0;
    enable = 1'b1;
    step();
    for (int k = 1; k < 6; k++) begin
      step();
      chk("h4_clk", 32'(clk_out), (k >= 4) ? 32'd1 : 32'd0);
    end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 8'd2;
    chk("h4_ready_pre", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("h4_ready_pend", 32'(cfg_if.cfg_ready), 32'd0);
    chk("h4_clk_e6",     32'(clk_out), 32'd1);
    step();
    chk("h4_clk_e7",     32'(clk_out), 32'd1);
    chk("h4_cur_e7",     32'(cur_half), 32'd4);
    chk("h4_ready_e7",   32'(cfg_if.cfg_ready), 32'd0);
    step();
    chk("h4_clk_bnd",    32'(clk_out), 32'd0);
    chk("h4_cur_bnd",    32'(cur_half), 32'd2);
    chk("h4_ready_bnd",  32'(cfg_if.cfg_ready), 32'd1);
    step();
    chk("h2_clk_e9",  32'(clk_out), 32'd0);
    step();
    chk("h2_clk_e10", 32'(clk_out), 32'd1);
    chk("h2_rise",    32'(rise_en), 32'd1);
    step();
    chk("h2_clk_e11", 32'(clk_out), 32'd1);
    chk("h2_rise_e11", 32'(rise_en), 32'd0);
    step();
    chk("h2_clk_e12", 32'(clk_out), 32'd0);
    step();
    chk("h2_clk_e13", 32'(clk_out), 32'd0);
    enable = 1'b0;
    step();
    chk("h2_stop_run", 32'(running), 32'd0);

    // H=5, disable two cycles into the high half
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 8'd5;
    step();
    cfg_if.cfg_valid = 1'b0;
    enable = 1'b1;
    step();
    for (int k = 1; k < 7; k++) step();
    chk("h5_clk_f6", 32'(clk_out), 32'd1);
    enable = 1'b0;
    for (int k = 7; k < 10; k++) begin
      step();
      chk("h5_stop_clk",   32'(clk_out), 32'd1);
      chk("h5_stop_run",   32'(running), 32'd1);
      chk("h5_stop_ready", 32'(cfg_if.cfg_ready), 32'd0);
    end
    step();
    chk("h5_off_clk",   32'(clk_out), 32'd0);
    chk("h5_off_run",   32'(running), 32'd0);
    chk("h5_off_ready", 32'(cfg_if.cfg_ready), 32'd1);

    // zero half-period is rejected
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 8'd0;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("zero_err",  32'(cfg_if.cfg_err), 32'd1);
    chk("zero_cur",  32'(cur_half), 32'd5);
    step();
    chk("zero_err_end", 32'(cfg_if.cfg_err), 32'd0);
    chk("zero_cur_end", 32'(cur_half), 32'd5);

    // async reset mid-high with H=3 and a pending change
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 8'd3;
    step();
    cfg_if.cfg_valid = 1'b0;
    enable = 1'b1;
    step();
    for (int k = 1; k < 4; k++) step();
    chk("ar_clk_high", 32'(clk_out), 32'd1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 8'd6;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("ar_pend_ready", 32'(cfg_if.cfg_ready), 32'd0);
    chk("ar_pend_clk",   32'(clk_out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_clk",   32'(clk_out), 32'd0);
    chk("ar_cur",   32'(cur_half), 32'd1);
    chk("ar_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("ar_run",   32'(running), 32'd0);
    chk("ar_rise",  32'(rise_en), 32'd0);
    enable = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("ar_post_cur", 32'(cur_half), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
